// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for memory_unit port initiators.
package mem_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 16;
    localparam int MEM_LEN_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_port_initiator_rd_tag_pipe.sv
// Valid/last tag shift register aligned to the RAM read latency.
module rd_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    input  logic in_last,
    output logic out_vld,
    output logic out_last
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q[0]  <= in_vld;
            last_q[0] <= in_vld & in_last;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_last = last_q[DEPTH-1];

endmodule

// File: rtl/mem_port_initiator.sv
// Burst initiator for one memory_unit port: issues one word per cycle,
// realigns read data to the fixed RAM latency.
import mem_pkg::*;

module mem_port_initiator #(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int LEN_W  = MEM_LEN_W,
    parameter int RD_LAT = 1
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e state_q;
    state_e state_d;

    logic             we_q;
    logic [LEN_W-1:0] cnt_q;
    logic             last_word;
    logic             tag_in_vld;
    logic             tag_out_vld;
    logic             tag_out_last;

    assign last_word  = (cnt_q == '0);
    assign tag_in_vld = (state_q == ST_ISSUE) && !we_q;

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tags (
        .clk      (clka),
        .rst_n    (rst_n),
        .in_vld   (tag_in_vld),
        .in_last  (last_word),
        .out_vld  (tag_out_vld),
        .out_last (tag_out_last)
    );

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (last_word) state_d = we_q ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tag_out_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            cnt_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= tag_out_vld;
            if (tag_out_vld) rsp_rdata <= mem_dout;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        cnt_q    <= req_len;
                        mem_we   <= req_we;
                        mem_addr <= req_addr;
                        if (req_we) mem_din <= req_wdata;
                    end
                end
                ST_ISSUE: begin
                    if (last_word) begin
                        mem_we <= 1'b0;
                    end else begin
                        // natural ADDR_W overflow gives the 0x3FFF -> 0 wrap
                        mem_addr <= mem_addr + ADDR_W'(1);
                        cnt_q    <= cnt_q - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed bench: RAM models at RD_LAT=1 (dut a) and RD_LAT=2 (dut b).
module tb_mem_port_initiator;

    logic        clka = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [13:0] req_addr;
    logic [3:0]  req_len;
    logic [15:0] req_wdata;
    logic        sel;

    logic        a_rdy, a_rv, a_done, a_we;
    logic [15:0] a_rd, a_din, a_dout;
    logic [13:0] a_addr;
    logic        b_rdy, b_rv, b_done, b_we;
    logic [15:0] b_rd, b_din, b_dout;
    logic [13:0] b_addr;

    logic        s_rdy, s_rv, s_done, s_we;
    logic [15:0] s_rd, s_din;
    logic [13:0] s_addr;

    logic [15:0] ram_a [0:16383];
    logic [15:0] ram_b [0:16383];
    logic [15:0] a_d1, b_d1, b_d2;
    logic [15:0] exp_d [16];

    int cyc = 0;
    int nvec = 0;
    int nerr = 0;
    int t0;

    always #5 clka = ~clka;
    always @(posedge clka) cyc <= cyc + 1;

    mem_port_initiator #(.RD_LAT(1)) u_a (
        .clka(clka), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(a_rdy),
        .req_we(req_we), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(a_rv), .rsp_rdata(a_rd), .done(a_done),
        .mem_we(a_we), .mem_addr(a_addr),
        .mem_din(a_din), .mem_dout(a_dout)
    );

    mem_port_initiator #(.RD_LAT(2)) u_b (
        .clka(clka), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(b_rdy),
        .req_we(req_we), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(b_rv), .rsp_rdata(b_rd), .done(b_done),
        .mem_we(b_we), .mem_addr(b_addr),
        .mem_din(b_din), .mem_dout(b_dout)
    );

    always @(posedge clka) begin
        if (a_we) ram_a[a_addr] <= a_din;
        a_d1 <= ram_a[a_addr];
        if (b_we) ram_b[b_addr] <= b_din;
        b_d1 <= ram_b[b_addr];
        b_d2 <= b_d1;
    end
    assign a_dout = a_d1;
    assign b_dout = b_d2;

    always_comb begin
        s_rdy  = sel ? b_rdy  : a_rdy;
        s_rv   = sel ? b_rv   : a_rv;
        s_done = sel ? b_done : a_done;
        s_we   = sel ? b_we   : a_we;
        s_rd   = sel ? b_rd   : a_rd;
        s_din  = sel ? b_din  : a_din;
        s_addr = sel ? b_addr : a_addr;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @%0d: got %h want %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_rst();
        check("rst_ready", s_rdy, 1);
        check("rst_we", s_we, 0);
        check("rst_addr", s_addr, 0);
        check("rst_din", s_din, 0);
        check("rst_rv", s_rv, 0);
        check("rst_done", s_done, 0);
        check("rst_rdata", s_rd, 0);
    endtask

    task automatic send(input bit s, input bit we, input logic [13:0] addr,
                        input logic [3:0] len, input logic [15:0] wd,
                        output int t);
        int n = 0;
        @(negedge clka);
        sel = s; req_we = we; req_addr = addr;
        req_len = len; req_wdata = wd; req_valid = 1'b1;
        #1;
        while (!s_rdy && n < 50) begin
            @(negedge clka); #1;
            n++;
        end
        check("accept", s_rdy, 1);
        t = cyc;
    endtask

    task automatic watch(input bit we, input logic [13:0] addr,
                         input logic [3:0] len, input logic [15:0] wd,
                         input int lat, input bit hold, input int t);
        int dr = we ? 2 + int'(len) : 2 + int'(len) + lat;
        for (int rel = 1; rel <= dr + 1; rel++) begin
            bit iss, rv;
            logic [13:0] ea;
            @(negedge clka);
            if (rel == 1 && !hold) req_valid = 1'b0;
            #1;
            iss = (rel <= 1 + int'(len));
            rv  = !we && rel >= 2 + lat && rel <= 2 + int'(len) + lat;
            ea  = addr + 14'(rel - 1);
            check("cycle", cyc - t, rel);
            check("mem_we", s_we, we && iss);
            if (iss) begin
                check("mem_addr", s_addr, ea);
                if (we) check("mem_din", s_din, wd);
            end
            check("rsp_valid", s_rv, rv);
            if (rv) check("rsp_rdata", s_rd, exp_d[rel-2-lat]);
            check("done", s_done, rel == dr);
            check("req_ready", s_rdy, rel > dr);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_len = '0; req_wdata = '0; sel = 1'b0;
        ram_b[0] = 16'd1; ram_b[1] = 16'd2; ram_b[2] = 16'd3;
        ram_a[14'h3FFE] = 16'hA000; ram_a[14'h3FFF] = 16'hA001;
        ram_a[14'h0000] = 16'hA002; ram_a[14'h0001] = 16'hA003;

        repeat (3) @(negedge clka);
        #1 check_rst();
        @(negedge clka) rst_n = 1'b1;

        send(0, 1, 14'h0010, 4'd0, 16'hBEEF, t0);
        watch(1, 14'h0010, 4'd0, 16'hBEEF, 1, 0, t0);
        exp_d[0] = 16'hBEEF;
        send(0, 0, 14'h0010, 4'd0, 16'h0, t0);
        watch(0, 14'h0010, 4'd0, 16'h0, 1, 0, t0);

        send(0, 1, 14'h0100, 4'd15, 16'h1234, t0);
        watch(1, 14'h0100, 4'd15, 16'h1234, 1, 0, t0);
        for (int i = 0; i < 16; i++) exp_d[i] = 16'h1234;
        send(0, 0, 14'h0100, 4'd15, 16'h0, t0);
        watch(0, 14'h0100, 4'd15, 16'h0, 1, 0, t0);

        for (int i = 0; i < 4; i++) exp_d[i] = 16'hA000 + 16'(i);
        send(0, 0, 14'h3FFE, 4'd3, 16'h0, t0);
        watch(0, 14'h3FFE, 4'd3, 16'h0, 1, 0, t0);

        for (int i = 0; i < 8; i++) exp_d[i] = 16'h1234;
        send(0, 0, 14'h0100, 4'd7, 16'h0, t0);
        watch(0, 14'h0100, 4'd7, 16'h0, 1, 1, t0);
        t0 = cyc;
        watch(0, 14'h0100, 4'd7, 16'h0, 1, 0, t0);

        exp_d[0] = 16'd1; exp_d[1] = 16'd2; exp_d[2] = 16'd3;
        send(1, 0, 14'h0000, 4'd2, 16'h0, t0);
        watch(0, 14'h0000, 4'd2, 16'h0, 2, 0, t0);

        send(0, 1, 14'h0200, 4'd15, 16'h5555, t0);
        @(negedge clka) req_valid = 1'b0;
        repeat (3) @(negedge clka);
        #1 check("pre_rst_we", s_we, 1);
        @(negedge clka);
        rst_n = 1'b0;
        #1 check_rst();
        @(negedge clka) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clka); #1;
            check("post_done", s_done, 0);
            check("post_we", s_we, 0);
            check("post_ready", s_rdy, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
